// File: rtl/pipe_controller.sv
// Pipelined control unit for the 5-stage ARM datapath: Decode-stage main/ALU decode,
// D->E/E->M/M->W control registers, Execute-stage condition check and NZCV flags register.
module pipe_controller #(
    parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [1:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemtoRegE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        MemtoRegW,
    output logic        RegWriteW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
);

    logic [3:0] condD;
    logic [1:0] opD;
    logic [5:0] functD;
    logic [3:0] rdD;

    logic       regWD, memWD, memtoRegD, aluSrcD, branchD, aluOpD, pcsD;
    logic [1:0] aluControlD, flagWD;

    logic       regWE, memWE, branchE, pcsE;
    logic [1:0] flagWE;
    logic [3:0] condE;
    logic       memtoRegM, pcsM;

    logic [3:0] flagsQ;
    logic       condEx;

    assign condD  = InstrD[31:28];
    assign opD    = InstrD[27:26];
    assign functD = InstrD[25:20];
    assign rdD    = InstrD[15:12];

    always_comb begin
        RegSrcD     = 2'b00;
        ImmSrcD     = 2'b00;
        aluSrcD     = 1'b0;
        memtoRegD   = 1'b0;
        regWD       = 1'b0;
        memWD       = 1'b0;
        branchD     = 1'b0;
        aluOpD      = 1'b0;
        aluControlD = 2'b00;
        flagWD      = 2'b00;
        case (opD)
            2'b00: begin
                aluSrcD = functD[5];
                aluOpD  = 1'b1;
            end
            2'b01: begin
                ImmSrcD = 2'b01;
                aluSrcD = 1'b1;
                if (functD[0]) begin
                    memtoRegD = 1'b1;
                    regWD     = 1'b1;
                end else begin
                    RegSrcD = 2'b10;
                    memWD   = 1'b1;
                end
            end
            2'b10: begin
                RegSrcD = 2'b01;
                ImmSrcD = 2'b10;
                aluSrcD = 1'b1;
                branchD = 1'b1;
            end
            default: ;
        endcase

        if (aluOpD) begin
            case (functD[4:1])
                4'b0100: begin
                    aluControlD = 2'b00;
                    regWD       = 1'b1;
                    flagWD      = functD[0] ? 2'b11 : 2'b00;
                end
                4'b0010: begin
                    aluControlD = 2'b01;
                    regWD       = 1'b1;
                    flagWD      = functD[0] ? 2'b11 : 2'b00;
                end
                4'b0000: begin
                    aluControlD = 2'b10;
                    regWD       = 1'b1;
                    flagWD      = functD[0] ? 2'b10 : 2'b00;
                end
                4'b1100: begin
                    aluControlD = 2'b11;
                    regWD       = 1'b1;
                    flagWD      = functD[0] ? 2'b10 : 2'b00;
                end
                4'b1010: begin
                    // CMP always updates flags, never writes a register
                    aluControlD = 2'b01;
                    flagWD      = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign pcsD = ((rdD == 4'hF) & regWD) | branchD;

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flagsQ;
        condEx = 1'b0;
        case (condE)
            4'b0000: condEx = z;
            4'b0001: condEx = ~z;
            4'b0010: condEx = c;
            4'b0011: condEx = ~c;
            4'b0100: condEx = n;
            4'b0101: condEx = ~n;
            4'b0110: condEx = v;
            4'b0111: condEx = ~v;
            4'b1000: condEx = c & ~z;
            4'b1001: condEx = ~c | z;
            4'b1010: condEx = (n == v);
            4'b1011: condEx = (n != v);
            4'b1100: condEx = ~z & (n == v);
            4'b1101: condEx = z | (n != v);
            4'b1110: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWE       <= 1'b0;
            memWE       <= 1'b0;
            MemtoRegE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= 2'b00;
            branchE     <= 1'b0;
            flagWE      <= 2'b00;
            pcsE        <= 1'b0;
            condE       <= 4'b0000;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            memtoRegM   <= 1'b0;
            pcsM        <= 1'b0;
            RegWriteW   <= 1'b0;
            MemtoRegW   <= 1'b0;
            PCSrcW      <= 1'b0;
        end else begin
            if (FlushE) begin
                regWE       <= 1'b0;
                memWE       <= 1'b0;
                MemtoRegE   <= 1'b0;
                ALUSrcE     <= 1'b0;
                ALUControlE <= 2'b00;
                branchE     <= 1'b0;
                flagWE      <= 2'b00;
                pcsE        <= 1'b0;
                condE       <= 4'b0000;
            end else begin
                regWE       <= regWD;
                memWE       <= memWD;
                MemtoRegE   <= memtoRegD;
                ALUSrcE     <= aluSrcD;
                ALUControlE <= aluControlD;
                branchE     <= branchD;
                flagWE      <= flagWD;
                pcsE        <= pcsD;
                condE       <= condD;
            end
            RegWriteM <= regWE & condEx;
            MemWriteM <= memWE & condEx;
            memtoRegM <= MemtoRegE;
            pcsM      <= pcsE & condEx;
            RegWriteW <= RegWriteM;
            MemtoRegW <= memtoRegM;
            PCSrcW    <= pcsM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flagsQ <= FLAGS_INIT;
        end else begin
            if (flagWE[1] & condEx) flagsQ[3:2] <= ALUFlags[3:2];
            if (flagWE[0] & condEx) flagsQ[1:0] <= ALUFlags[1:0];
        end
    end

    assign BranchTakenE = branchE & condEx;
    // E-stage term is ungated: the fetch unit must hold off until the condition resolves
    assign PCWrPendingF = pcsD | pcsE | pcsM;

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
- Pipelined control unit for the 5-stage ARM datapath.
- Decodes InstrD in the Decode stage and carries the control bits through E/M/W pipeline registers, alongside the datapath's own stage registers.
- Evaluates condition codes in Execute against a NZCV flags register.
- Exposes stage-aligned control outputs, plus the signals the hazard unit needs.

Parameters:
FLAGS_INIT, 4'b0000, NZCV value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
InstrD  in  32  instruction in Decode; uses [31:28] Cond, [27:26] Op, [25:20] Funct, [15:12] Rd
ALUFlags  in  4  NZCV from the ALU in Execute
FlushE  in  1  synchronous clear of the D->E control register (bubble)
RegSrcD  out  2  register-address select, Decode
ImmSrcD  out  2  extend select, Decode
ALUSrcE  out  1  SrcB select (1 = ExtImm), Execute
ALUControlE  out  2  00 add, 01 sub, 10 and, 11 orr
BranchTakenE  out  1  conditional branch taken, Execute
MemtoRegE  out  1  load in Execute (hazard unit)
RegWriteM  out  1  gated register write, Memory
MemWriteM  out  1  gated data-memory write, Memory
MemtoRegW  out  1  result select (1 = ReadData), Writeback
RegWriteW  out  1  register write enable, Writeback
PCSrcW  out  1  PC loaded from ResultW
PCWrPendingF  out  1  PCSD | PCSE | PCSM

Behaviour:
Main decode (combinational, Decode stage):
- Op=00, data-processing:
  - RegSrc=00, ImmSrc=00, ALUSrc=Funct[5], MemtoReg=0, MemW=0, Branch=0, ALUOp=1.
- Op=01, memory:
  - ImmSrc=01, ALUSrc=1, Branch=0, ALUOp=0, ALUControl=00.
  - Funct[0]=1 (LDR): RegSrc=00, MemtoReg=1, RegW=1, MemW=0.
  - Funct[0]=0 (STR): RegSrc=10, MemtoReg=0, RegW=0, MemW=1.
- Op=10, branch:
  - RegSrc=01, ImmSrc=10, ALUSrc=1, Branch=1, RegW=0, MemW=0, ALUControl=00.
- Op=11: NOP; every write, Branch and FlagW are 0.

ALU decode (ALUOp=1), cmd=Funct[4:1], S=Funct[0]:
- 0100 ADD -> ALUControl=00, RegW=1.
- 0010 SUB -> 01, RegW=1.
- 0000 AND -> 10, RegW=1.
- 1100 ORR -> 11, RegW=1.
- 1010 CMP -> 01, RegW=0, FlagW=11 regardless of S.
- Any other cmd: NOP (RegW=0, FlagW=0).
- FlagW when S=1: 11 for ADD/SUB, 10 for AND/ORR; FlagW=00 when S=0.
- PCSD = (Rd==4'hF & RegW) | Branch.

Pipeline:
- D->E register holds RegW, MemW, MemtoReg, ALUSrc, ALUControl, Branch, FlagW, PCS, Cond.
- On FlushE the D->E register loads all zeros; E->M and M->W are unaffected.
- E->M register holds the gated RegW, MemW and PCS plus MemtoReg; M->W register holds RegW, MemtoReg and PCS.
- Latency from decode: E-stage outputs at +1 cycle, M-stage outputs at +2, W-stage outputs at +3.
- No stall input; the hazard unit inserts bubbles via FlushE.

Condition (Execute):
- CondEx is the standard 4-bit ARM decode of CondE against FlagsQ (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE).
- 1110 = always; 1111 = never.
- Gating of E-stage signals:
  - RegWriteE, MemWriteE and PCSE are ANDed with CondEx before the E->M register.
  - BranchTakenE = BranchE & CondEx.

Flags register:
- NZ (FlagsQ[3:2]) loads ALUFlags[3:2] at clk when FlagWE[1] & CondEx.
- CV (FlagsQ[1:0]) loads ALUFlags[1:0] at clk when FlagWE[0] & CondEx.
- An instruction in E sees the flags written by the previous instruction.

Reset:
- Asynchronous; every pipeline register clears to 0 (bubble) and FlagsQ = FLAGS_INIT.
- All registered outputs are 0 while reset is high. The Decode-stage outputs RegSrcD and ImmSrcD still follow InstrD.
- Reset mid-stream drops in-flight instructions.
- Reset has priority over FlushE.

Test Plan:
1. Reset: with an ADD in M, assert reset between edges -> RegWriteM, RegWriteW, MemWriteM and PCSrcW go to 0 immediately, without waiting for an edge; FlagsQ = 0000.
2. ADD R1,R2,#5 (InstrD=E2821005) -> RegSrcD=00, ImmSrcD=00; at +1 ALUSrcE=1, ALUControlE=00; at +2 RegWriteM=1; at +3 RegWriteW=1, MemtoRegW=0.
3. SUBS R0,R0,R0 (E0500000) with ALUFlags=0100 in E, then BEQ (0A000002) -> BranchTakenE=1. Then a CMP with ALUFlags=0000, then BEQ -> BranchTakenE=0.
4. STR R1,[R0] (E5801000) -> RegSrcD=10, ImmSrcD=01; at +2 MemWriteM=1; at +3 RegWriteW=0.
5. LDREQ R1 (05901000) with Z=0 -> MemtoRegE=1 at +1; RegWriteM=0 at +2; RegWriteW=0 at +3.
6. Flush and PC-write cases:
   - FlushE with an ADD in Decode -> ALUSrcE=0 next cycle; RegWriteW stays 0.
   - LDR R15 (E590F000) -> PCWrPendingF=1 for three cycles; PCSrcW=1 at +3.
